// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: pipelined multiply, 32-step restoring divide.
// Optional macro MD_DIV0_FAST_EN: divide-by-zero is detected at accept and completes in one cycle.
module md_sequencer #(
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        mul_or_div,
   input  logic        is_sign,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int CNT_W = 6;
   localparam int PD    = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sa, r_sb;
   logic [31:0]        r_ma, r_mb;
   logic [63:0]        r_rq;
   logic [63:0]        r_prod [PD];
   logic [31:0]        r_hi, r_lo;

   logic               w_accept, w_fast0, w_enter_done, w_ge;
   logic [31:0]        w_abs_a, w_abs_b, w_diff, w_quo, w_rem;
   logic [63:0]        w_ab, w_tap, w_prod_s, w_step;
   logic [31:0]        w_res_hi, w_res_lo;

   assign w_accept = (r_state == S_IDLE) & start & ~flush;
   assign w_abs_a  = (is_sign & src_a[31]) ? (~src_a + 32'd1) : src_a;
   assign w_abs_b  = (is_sign & src_b[31]) ? (~src_b + 32'd1) : src_b;

`ifdef MD_DIV0_FAST_EN
   assign w_fast0 = mul_or_div & (src_b == 32'd0);
`else
   assign w_fast0 = 1'b0;
`endif

   // Restoring step: the shifted partial remainder is 33 bits wide before the compare
   assign w_ge   = (r_rq[63:31] >= {1'b0, r_mb});
   assign w_diff = r_rq[62:31] - r_mb;
   assign w_step = w_ge ? {w_diff, r_rq[30:0], 1'b1} : {r_rq[62:0], 1'b0};

   assign w_ab     = r_ma * r_mb;
   assign w_tap    = (MUL_LAT == 1) ? w_ab : r_prod[PD-1];
   assign w_prod_s = (r_sa ^ r_sb) ? (~w_tap + 64'd1) : w_tap;
   assign w_quo    = (r_sa ^ r_sb) ? (~w_step[31:0] + 32'd1) : w_step[31:0];
   assign w_rem    = r_sa ? (~w_step[63:32] + 32'd1) : w_step[63:32];

   always_comb begin
      w_res_hi = w_prod_s[63:32];
      w_res_lo = w_prod_s[31:0];
      case (r_state)
         S_IDLE: begin
            w_res_hi = src_a;
            w_res_lo = 32'hFFFF_FFFF;
         end
         S_DIV: begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
         end
         default: ;
      endcase
   end

   assign w_enter_done = (w_next == S_DONE) & (r_state != S_DONE);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_fast0)         w_next = S_DONE;
               else if (mul_or_div) w_next = S_DIV;
               else                 w_next = S_MUL;
            end
         end
         S_MUL: begin
            if (flush)                                w_next = S_IDLE;
            else if (r_cnt == CNT_W'(MUL_LAT - 1))    w_next = S_DONE;
         end
         S_DIV: begin
            if (flush)                                w_next = S_IDLE;
            else if (r_cnt == CNT_W'(DIV_ITER - 1))   w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs; gated by resetn so a held start cannot stall the pipe during reset
   always_comb begin
      stall        = 1'b0;
      result_valid = 1'b0;
      case (r_state)
         S_IDLE:       stall        = start & ~flush & resetn;
         S_MUL, S_DIV: stall        = ~flush & resetn;
         S_DONE:       result_valid = ~flush & resetn;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
         r_sa  <= 1'b0;
         r_sb  <= 1'b0;
         r_ma  <= '0;
         r_mb  <= '0;
         r_rq  <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         for (int i = 0; i < PD; i++) r_prod[i] <= '0;
      end else begin
         if (w_accept) begin
            r_cnt <= '0;
            r_sa  <= is_sign & src_a[31];
            r_sb  <= is_sign & src_b[31];
            r_ma  <= w_abs_a;
            r_mb  <= w_abs_b;
            r_rq  <= {32'd0, w_abs_a};
         end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_MUL) begin
            r_prod[0] <= w_ab;
            for (int i = 1; i < PD; i++) r_prod[i] <= r_prod[i-1];
         end
         if (r_state == S_DIV) r_rq <= w_step;
         if (w_enter_done) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end
   end

   assign hi_out = r_hi;
   assign lo_out = r_lo;

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage.
- Accepts a MULT/MULTU/DIV/DIVU request from the decoded control (mdToHilo, mulOrdiv, mdIsSign) with rs/rt operands.
- Holds the pipeline through a pipelined multiply or a 32-iteration restoring divide, then presents a one-cycle HI/LO result for the hilo_reg write.
- Supports cancellation by exception flush.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (1..8); product register pipeline depth.
- DIV_ITER, 32, divide iterations; fixed at 32, not for override.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  mdToHilo of the instruction in EX; level-held while stalled
- mul_or_div  input  1  0 = multiply, 1 = divide
- is_sign  input  1  1 = MULT/DIV, 0 = MULTU/DIVU
- src_a  input  32  rs value (multiplicand / dividend)
- src_b  input  32  rt value (multiplier / divisor)
- flush  input  1  exception/eret flush of EX; cancels the operation
- stall  output  1  hold PC/IF/ID/EX while 1
- result_valid  output  1  one-cycle pulse; HI/LO write enable
- hi_out  output  32  product[63:32] / remainder
- lo_out  output  32  product[31:0] / quotient

Behaviour:
- Reset (async, resetn=0): state IDLE; counter, operand and result registers 0; stall=0, result_valid=0, hi_out=lo_out=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0 → accept (cycle 0): latch operands, sign flags and |a|, |b| (when is_sign).
  - Next state MUL or DIV; counter loaded with 0.
- MUL: product of magnitudes registered through MUL_LAT stages. After MUL_LAT cycles in MUL → DONE. result_valid occurs in cycle MUL_LAT+1 after accept.
- DIV:
  - One restoring shift-subtract step per cycle on a 64-bit {rem, quo} register.
  - 32 steps (cycles 1..32) → DONE; result_valid in cycle 33.
- Sign fix, applied combinationally when entering DONE:
  - Signed product is negated iff sign(a) != sign(b).
  - Quotient is negated iff the signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed → lo=0x80000000, hi=0 (wraps).
- DONE: result_valid=1 for exactly one cycle with hi_out/lo_out valid; stall=0; next state IDLE. hi_out/lo_out hold their values until the next DONE.
- stall = (IDLE & start & ~flush) | MUL | DIV, with ~flush forced in MUL/DIV. stall is 0 in DONE so the instruction leaves EX that same cycle.
- start in the DONE cycle is ignored: the same instruction must not restart. A new operation is accepted only from IDLE.
- Flush:
  - In MUL/DIV: stall drops the same cycle; next state IDLE; no result_valid; result registers unchanged.
  - In DONE: result_valid is suppressed that cycle.
  - In IDLE: the request is not accepted.
- Reset mid-operation: immediate IDLE, all outputs 0.
- Divide by zero (macro off):
  - Runs the full 32 iterations.
  - Unsigned result is lo=0xFFFFFFFF, hi=src_a.
  - Signed values are architecturally unpredictable; only the timing is checked.

Optional Feature:
- Macro MD_DIV0_FAST_EN.
- Defined: divisor 0 is detected at accept; DIV is skipped and DONE follows in cycle 1. Result is hi=src_a, lo=0xFFFFFFFF for both signed and unsigned.
- Undefined: no detection; behaviour as described under Behaviour (33-cycle latency).

Test Plan:
- MULT, a=0xFFFFFFFE, b=3, MUL_LAT=2 → stall high cycles 0–2, result_valid in cycle 3, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=0xFFFFFFF9 (−7), b=2 → result_valid in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU, a=100, b=7 → lo=0xE, hi=0x2.
- DIV started, flush in cycle 10 → stall=0 in cycle 10, IDLE in cycle 11, no result_valid; the following DIVU 100/7 completes correctly.
- resetn pulled low in cycle 5 of a DIV → stall=0 and outputs 0 immediately; start held after release → new accept with correct result.
- With MD_DIV0_FAST_EN, DIV a=0x12345678, b=0 → result_valid in cycle 1, hi=0x12345678, lo=0xFFFFFFFF; without the macro → result_valid in cycle 33.
